linear_filter_mul_scheduler: RTL and testbench

Round-robin scheduler sharing one registered signed multiplier (32x32->32, one register stage, `ce`-gated) among NUM_REQ requesters inside the linear image filter datapath. Each requester presents operand pairs with a valid/ready handshake. The block drives the multiplier's `ce` and operand inputs, and tracks which requester owns the product in flight. Results return on a single tagged response channel with backpressure, buffered in a 2-entry FIFO.

---
 rtl/linear_filter_mul_scheduler_if.sv | 31 +++
 rtl/linear_filter_mul_scheduler.sv | 141 ++++++++++++++
 tb/tb_linear_filter_mul_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/linear_filter_mul_scheduler_if.sv
// Operand/response bundle between the linear filter requesters, the shared multiplier and
// linear_filter_mul_scheduler; the scheduler side uses the slave modport.
interface linear_filter_mul_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);
  logic                          sched_en;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          mul_ce;
  logic [DATA_WIDTH-1:0]         mul_din0;
  logic [DATA_WIDTH-1:0]         mul_din1;
  logic [DATA_WIDTH-1:0]         mul_dout;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [ID_WIDTH-1:0]           resp_id;
  logic [DATA_WIDTH-1:0]         resp_data;

  modport master (
    output sched_en, req_valid, req_a, req_b, mul_dout, resp_ready,
    input  req_ready, mul_ce, mul_din0, mul_din1, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  sched_en, req_valid, req_a, req_b, mul_dout, resp_ready,
    output req_ready, mul_ce, mul_din0, mul_din1, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/linear_filter_mul_scheduler.sv
// Round-robin sharing of one registered multiplier among NUM_REQ requesters, results returned
// through a 2-entry tagged FIFO. Define LINEAR_FILTER_MUL_SCHED_STATS_EN for issue/stall counters.
module linear_filter_mul_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic clk,
  input  logic reset,
  linear_filter_mul_scheduler_if.slave bus
`ifdef LINEAR_FILTER_MUL_SCHED_STATS_EN
  ,
  output logic [31:0] stat_issue_cnt,
  output logic [31:0] stat_stall_cnt
`endif
);

  logic [ID_WIDTH-1:0]   last_grant_reg;
  logic                  inflight_v_reg;
  logic [ID_WIDTH-1:0]   inflight_id_reg;
  logic [DATA_WIDTH-1:0] din0_reg;
  logic [DATA_WIDTH-1:0] din1_reg;
  logic [1:0]            fifo_count_reg;
  logic                  rd_ptr_reg;
  logic                  wr_ptr_reg;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [ID_WIDTH-1:0]   fifo_id [2];

  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [NUM_REQ-1:0]    grant_oh;
  logic [DATA_WIDTH-1:0] a_masked [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_masked [NUM_REQ];
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic                  resp_valid_int;
  logic                  pop;
  logic                  push;
  logic [2:0]            credit_used;
  logic                  credit_ok;
  logic                  issue;

  // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid at or below it.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (i <= int'(last_grant_reg))) begin
        grant_found = 1'b1;
        grant_id    = ID_WIDTH'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (i > int'(last_grant_reg))) begin
        grant_found = 1'b1;
        grant_id    = ID_WIDTH'(i);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign grant_oh[gi] = grant_found && (grant_id == ID_WIDTH'(gi));
      assign a_masked[gi] = bus.req_a[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_oh[gi]}};
      assign b_masked[gi] = bus.req_b[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_oh[gi]}};
    end
  endgenerate

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_sel = a_sel | a_masked[i];
      b_sel = b_sel | b_masked[i];
    end
  end

  assign resp_valid_int = (fifo_count_reg != 2'd0);
  assign pop            = resp_valid_int & bus.resp_ready;
  assign push           = inflight_v_reg;
  // A slot is reserved for the in-flight product so the FIFO can never overflow.
  assign credit_used    = 3'(inflight_v_reg) + 3'(fifo_count_reg) - 3'(pop);
  assign credit_ok      = (credit_used < 3'd2);
  // Gating with reset keeps grants off while reset is held.
  assign issue          = reset & bus.sched_en & grant_found & credit_ok;

  assign bus.req_ready  = grant_oh & {NUM_REQ{issue}};
  assign bus.mul_ce     = issue;
  assign bus.mul_din0   = issue ? a_sel : din0_reg;
  assign bus.mul_din1   = issue ? b_sel : din1_reg;
  assign bus.resp_valid = resp_valid_int;
  assign bus.resp_id    = resp_valid_int ? fifo_id[rd_ptr_reg] : '0;
  assign bus.resp_data  = resp_valid_int ? fifo_data[rd_ptr_reg] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_reg  <= ID_WIDTH'(NUM_REQ - 1);
      inflight_v_reg  <= 1'b0;
      inflight_id_reg <= '0;
      din0_reg        <= '0;
      din1_reg        <= '0;
      fifo_count_reg  <= 2'd0;
      rd_ptr_reg      <= 1'b0;
      wr_ptr_reg      <= 1'b0;
    end else begin
      inflight_v_reg <= issue;
      if (issue) begin
        inflight_id_reg <= grant_id;
        last_grant_reg  <= grant_id;
        din0_reg        <= a_sel;
        din1_reg        <= b_sel;
      end
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      fifo_count_reg <= fifo_count_reg + 2'(push) - 2'(pop);
    end
  end

  // Storage needs no reset: the head is masked off whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_reg] <= bus.mul_dout;
      fifo_id[wr_ptr_reg]   <= inflight_id_reg;
    end
  end

`ifdef LINEAR_FILTER_MUL_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (issue) stat_issue_cnt <= stat_issue_cnt + 32'd1;
      if (bus.sched_en && (|bus.req_valid) && !issue) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_linear_filter_mul_scheduler.sv
// Bench for linear_filter_mul_scheduler: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based reference of the scheduler.
module tb_linear_filter_mul_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  linear_filter_mul_scheduler_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

`ifdef LINEAR_FILTER_MUL_SCHED_STATS_EN
  logic [31:0] stat_issue_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  linear_filter_mul_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef LINEAR_FILTER_MUL_SCHED_STATS_EN
    ,
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  function automatic logic [31:0] mul32(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return p[31:0];
  endfunction

  // Shared multiplier: one register stage, clock-enabled.
  always @(posedge clk) begin
    if (bus.mul_ce) bus.mul_dout <= mul32(bus.mul_din0, bus.mul_din1);
  end

  typedef struct {
    int          id;
    logic [31:0] data;
    int          cyc;
  } item_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] a_op [N];
  logic [31:0] b_op [N];
  item_t       m_fifo [$];
  item_t       obs_q [$];
  int          grant_log [$];
  int          grant_cyc [$];
  bit          m_infl_v;
  item_t       m_infl;
  int          m_last;
  logic [31:0] m_a;
  logic [31:0] m_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_infl_v = 1'b0;
    m_last   = N - 1;
    m_a      = '0;
    m_b      = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready",  64'(bus.req_ready),  64'd0);
    check("rst_mul_ce",     64'(bus.mul_ce),     64'd0);
    check("rst_mul_din0",   64'(bus.mul_din0),   64'd0);
    check("rst_mul_din1",   64'(bus.mul_din1),   64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_id",    64'(bus.resp_id),    64'd0);
    check("rst_resp_data",  64'(bus.resp_data),  64'd0);
  endtask

  // Called at a falling edge with inputs set; checks one cycle and advances the reference.
  task automatic run_cycle();
    int          g;
    bit          pop;
    bit          credit;
    bit          issue;
    logic [N-1:0] exp_ready;
    logic [31:0] e0;
    logic [31:0] e1;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*DW +: DW] = a_op[i];
      bus.req_b[i*DW +: DW] = b_op[i];
    end
    #1;
    pop    = (m_fifo.size() > 0) && bus.resp_ready;
    credit = (int'(m_infl_v) + m_fifo.size() - int'(pop)) < 2;
    g = -1;
    if (rst_n && bus.sched_en && credit) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (g < 0 && bus.req_valid[c]) g = c;
      end
    end
    issue     = (g >= 0);
    exp_ready = '0;
    if (issue) exp_ready[g] = 1'b1;
    e0 = issue ? a_op[g] : m_a;
    e1 = issue ? b_op[g] : m_b;
    check("req_ready",  64'(bus.req_ready),  64'(exp_ready));
    check("mul_ce",     64'(bus.mul_ce),     64'(issue));
    check("mul_din0",   64'(bus.mul_din0),   64'(e0));
    check("mul_din1",   64'(bus.mul_din1),   64'(e1));
    check("resp_valid", 64'(bus.resp_valid), 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      check("resp_id",   64'(bus.resp_id),   64'(m_fifo[0].id));
      check("resp_data", 64'(bus.resp_data), 64'(m_fifo[0].data));
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i]) begin
        grant_log.push_back(i);
        grant_cyc.push_back(cyc);
      end
    end
    if (bus.resp_valid && bus.resp_ready) begin
      obs_q.push_back('{int'(bus.resp_id), bus.resp_data, cyc});
      $display("cycle %0d resp id=%0d data=%08h", cyc, bus.resp_id, bus.resp_data);
    end
    @(posedge clk);
    if (rst_n) begin
      if (pop) void'(m_fifo.pop_front());
      if (m_infl_v) m_fifo.push_back(m_infl);
      m_infl_v = issue;
      if (issue) begin
        m_infl.id   = g;
        m_infl.data = mul32(a_op[g], b_op[g]);
        m_infl.cyc  = cyc;
        m_last      = g;
        m_a         = a_op[g];
        m_b         = b_op[g];
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset in the middle of a cycle and checks outputs clear without waiting for a clock.
  task automatic apply_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
`ifdef LINEAR_FILTER_MUL_SCHED_STATS_EN
    check("rst_stat_issue", 64'(stat_issue_cnt), 64'd0);
    check("rst_stat_stall", 64'(stat_stall_cnt), 64'd0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tmp;
    int          exp_d [4];
    int          first_g;
    exp_d = '{-2, -6, -12, -20};
    model_reset();

    // Reset held with every requester asking: nothing may be granted.
    bus.sched_en   = 1'b1;
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_op[i] = 32'(i + 1);
      b_op[i] = 32'(-(i + 2));
      bus.req_a[i*DW +: DW] = a_op[i];
      bus.req_b[i*DW +: DW] = b_op[i];
    end
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with all requesters valid.
    grant_log.delete(); grant_cyc.delete(); obs_q.delete();
    repeat (5) run_cycle();
    bus.req_valid = '0;
    repeat (3) run_cycle();
    check("rr_grant_count", 64'(grant_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) check("rr_grant_order", 64'(grant_log[k]), 64'(k % N));
    check("rr_resp_count", 64'(obs_q.size()), 64'd5);
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      tmp = exp_d[k];
      check("rr_resp_id", 64'(obs_q[k].id), 64'(k));
      check("rr_resp_data", 64'(obs_q[k].data), 64'(tmp));
    end
    if (obs_q.size() > 0 && grant_cyc.size() > 0)
      check("rr_first_latency", 64'(obs_q[0].cyc - grant_cyc[0]), 64'd2);

    // Backpressure: two outstanding products, then grants stop.
    grant_log.delete(); obs_q.delete();
    bus.req_valid = 4'b0010; a_op[1] = 32'd7; b_op[1] = 32'd6; bus.resp_ready = 1'b0;
    repeat (6) run_cycle();
    check("bp_grant_count", 64'(grant_log.size()), 64'd2);
    check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
    check("bp_resp_data", 64'(bus.resp_data), 64'd42);
    check("bp_resp_id", 64'(bus.resp_id), 64'd1);
    bus.resp_ready = 1'b1;
    grant_log.delete();
    run_cycle();
    check("bp_resume_grant", 64'(grant_log.size()), 64'd1);
    bus.req_valid = '0;
    repeat (4) run_cycle();

    // Truncated signed products at the extremes.
    obs_q.delete();
    a_op[2] = 32'h7FFF_FFFF; b_op[2] = 32'd2;
    a_op[3] = 32'h8000_0000; b_op[3] = 32'hFFFF_FFFF;
    bus.req_valid = 4'b0100; run_cycle();
    bus.req_valid = 4'b1000; run_cycle();
    bus.req_valid = '0;
    repeat (3) run_cycle();
    check("ovf_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() >= 2) begin
      check("ovf_data0", 64'(obs_q[0].data), 64'h0000_0000_FFFF_FFFE);
      check("ovf_data1", 64'(obs_q[1].data), 64'h0000_0000_8000_0000);
      check("ovf_id1", 64'(obs_q[1].id), 64'd3);
    end

    // sched_en dropped right after an issue: the product still drains.
    obs_q.delete();
    a_op[0] = $urandom; b_op[0] = $urandom;
    tmp = mul32(a_op[0], b_op[0]);
    bus.req_valid = 4'b0001; run_cycle();
    bus.sched_en = 1'b0; bus.req_valid = 4'b1111;
    grant_log.delete();
    repeat (4) run_cycle();
    check("drain_no_grant", 64'(grant_log.size()), 64'd0);
    check("drain_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() >= 1) begin
      check("drain_id", 64'(obs_q[0].id), 64'd0);
      check("drain_data", 64'(obs_q[0].data), 64'(tmp));
    end

    // Reset with one product in flight and one in the FIFO.
    bus.sched_en = 1'b1; bus.resp_ready = 1'b0; bus.req_valid = '0;
    run_cycle();
    bus.req_valid = 4'b0001; run_cycle();
    bus.req_valid = 4'b0010; run_cycle();
    bus.req_valid = 4'b1111;
    apply_reset_mid();
    bus.resp_ready = 1'b1;
    grant_log.delete(); obs_q.delete();
    run_cycle();
    first_g = (grant_log.size() > 0) ? grant_log[0] : -1;
    check("post_rst_first_grant", 64'(first_g), 64'd0);
    check("post_rst_no_stale", 64'(obs_q.size()), 64'd0);
    bus.req_valid = '0;
    repeat (3) run_cycle();

    // Random traffic against the reference.
    for (int n = 0; n < 400; n++) begin
      bus.req_valid  = N'($urandom_range(0, (1 << N) - 1));
      bus.sched_en   = ($urandom_range(0, 9) != 0);
      bus.resp_ready = ($urandom_range(0, 9) < 6);
      for (int i = 0; i < N; i++) begin
        a_op[i] = $urandom;
        b_op[i] = $urandom;
      end
      run_cycle();
    end
    bus.req_valid = '0; bus.resp_ready = 1'b1;
    repeat (4) run_cycle();

`ifdef LINEAR_FILTER_MUL_SCHED_STATS_EN
    // 10 issues, then 3 stalled cycles once credit runs out.
    apply_reset_mid();
    bus.sched_en = 1'b1; bus.resp_ready = 1'b1; bus.req_valid = 4'b0001;
    repeat (10) run_cycle();
    bus.resp_ready = 1'b0;
    repeat (3) run_cycle();
    bus.sched_en = 1'b0;
    run_cycle();
    check("stat_issue_cnt", 64'(stat_issue_cnt), 64'd10);
    check("stat_stall_cnt", 64'(stat_stall_cnt), 64'd3);
    bus.resp_ready = 1'b1; bus.req_valid = '0;
    repeat (3) run_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
